// File: rtl/uart_pkg.sv
// ============================================================================
//  Module  : uart_pkg
//  Brief   : Shared constants, arbiter state type and header-byte helper.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int         UART_DATA_W  = 8;
   localparam logic [3:0] UART_HDR_TAG = 4'hA;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } arb_state_t;

   function automatic logic [UART_DATA_W-1:0] uart_hdr_byte(input logic [3:0] id);
      return {UART_HDR_TAG, id};
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rr_pick.sv
// ============================================================================
//  Module  : uart_rr_pick
//  Brief   : Combinational rotating-priority picker, first request at or above ptr.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rr_pick
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]    o_id,
   output logic               o_any
);

   logic [ID_W:0]   w_sum;
   logic [ID_W-1:0] w_idx;
   logic            w_found;

   assign o_any = |i_req;

   // ptr is always below NUM_REQ, so one conditional subtract performs the wrap
   always_comb begin
      o_gnt   = '0;
      o_id    = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
         if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (ID_W+1)'(NUM_REQ);
         end
         w_idx = w_sum[ID_W-1:0];
         if (!w_found && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            o_id         = w_idx;
            w_found      = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module  : uart_tx_arbiter
//  Brief   : Packet-locked round-robin arbiter sharing the uart_tx byte channel.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int HEADER_EN = 1,
   parameter int TIMEOUT   = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             i_req_valid,
   input  logic [UART_DATA_W*NUM_REQ-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]             i_req_last,
   output logic [NUM_REQ-1:0]             o_req_ready,
   output logic                           o_tx_valid,
   output logic [UART_DATA_W-1:0]         o_tx_data,
   input  logic                           i_tx_ready,
   output logic [NUM_REQ-1:0]             o_grant,
   output logic                           o_busy,
   output logic                           o_timeout_evt
);

   localparam int                   c_ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int                   c_STALL_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_STALL_W-1:0] c_STALL_MAX = c_STALL_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   arb_state_t             r_state;
   logic [c_ID_W-1:0]      r_ptr;
   logic [c_ID_W-1:0]      r_gid;
   logic [NUM_REQ-1:0]     r_grant;
   logic [c_STALL_W-1:0]   r_stall;
   logic                   r_timeout_evt;

   logic [NUM_REQ-1:0]     w_pick_gnt;
   logic [c_ID_W-1:0]      w_pick_id;
   logic                   w_pick_any;
   logic [UART_DATA_W-1:0] w_req_byte [NUM_REQ];
   logic                   w_sel_valid;
   logic                   w_sel_last;
   logic [UART_DATA_W-1:0] w_sel_data;
   logic [c_ID_W-1:0]      w_next_ptr;
   logic                   w_xfer;
   logic                   w_stall_expired;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (c_ID_W)
   ) u_pick (
      .i_req   (i_req_valid),
      .i_ptr   (r_ptr),
      .o_gnt   (w_pick_gnt),
      .o_id    (w_pick_id),
      .o_any   (w_pick_any)
   );

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_req_byte[g] = i_req_data[g*UART_DATA_W +: UART_DATA_W];
   end

   assign w_sel_valid     = i_req_valid[r_gid];
   assign w_sel_last      = i_req_last[r_gid];
   assign w_sel_data      = w_req_byte[r_gid];
   assign w_next_ptr      = (r_gid == c_ID_W'(NUM_REQ - 1)) ? '0 : r_gid + 1'b1;
   assign w_xfer          = o_tx_valid & i_tx_ready;
   assign w_stall_expired = (TIMEOUT != 0) && (r_stall == c_STALL_MAX);

   // Gated by rst so nothing is offered or accepted in the reset cycle
   always_comb begin
      o_tx_valid  = 1'b0;
      o_tx_data   = '0;
      o_req_ready = '0;
      if (!rst) begin
         case (r_state)
            HDR: begin
               o_tx_valid = 1'b1;
               o_tx_data  = uart_hdr_byte(4'(r_gid));
            end
            DATA: begin
               o_tx_valid         = w_sel_valid;
               o_tx_data          = w_sel_data;
               o_req_ready[r_gid] = i_tx_ready;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_ptr         <= '0;
         r_gid         <= '0;
         r_grant       <= '0;
         r_stall       <= '0;
         r_timeout_evt <= 1'b0;
      end else begin
         r_timeout_evt <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pick_any) begin
                  r_grant <= w_pick_gnt;
                  r_gid   <= w_pick_id;
                  r_stall <= '0;
                  r_state <= (HEADER_EN != 0) ? HDR : DATA;
               end
            end
            HDR: begin
               if (i_tx_ready) begin
                  r_stall <= '0;
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_xfer) begin
                  r_stall <= '0;
                  if (w_sel_last) begin
                     r_state <= IDLE;
                     r_ptr   <= w_next_ptr;
                     r_grant <= '0;
                  end
               end else if (!w_sel_valid) begin
                  // Only valid-low cycles count, so last and timeout never collide
                  if (w_stall_expired) begin
                     r_state       <= IDLE;
                     r_ptr         <= w_next_ptr;
                     r_grant       <= '0;
                     r_stall       <= '0;
                     r_timeout_evt <= 1'b1;
                  end else begin
                     r_stall <= r_stall + 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_grant       = r_grant;
   assign o_busy        = (r_state != IDLE);
   assign o_timeout_evt = r_timeout_evt;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  Module  : tb_uart_tx_arbiter
//  Brief   : Scoreboard bench for uart_tx_arbiter, header and no-header builds.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

   typedef struct packed {
      logic [7:0]  data;
      logic [3:0]  gnt;
      logic [15:0] gap;
      logic        from_mark;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic        tx_ready;
   logic        use_n;
   int          tx_mode;

   logic [3:0] h_req_ready, n_req_ready, h_grant, n_grant;
   logic [7:0] h_tx_data, n_tx_data;
   logic       h_tx_valid, n_tx_valid, h_busy, n_busy, h_to, n_to_evt;

   logic [3:0] w_req_ready, w_grant;
   logic [7:0] w_tx_data;
   logic       w_tx_valid, w_busy, w_timeout;

   exp_t       sb[$];
   logic [8:0] rmem [4][16];
   int         rhead [4];
   int         rtail [4];
   int         cyc, mark_cyc, last_xfer, exp_to_gap, n_to;
   int         n_cmp, n_bad;

   uart_tx_arbiter #(.NUM_REQ(4), .HEADER_EN(1), .TIMEOUT(8)) dut_h (
      .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
      .i_req_last(req_last), .o_req_ready(h_req_ready), .o_tx_valid(h_tx_valid),
      .o_tx_data(h_tx_data), .i_tx_ready(tx_ready), .o_grant(h_grant),
      .o_busy(h_busy), .o_timeout_evt(h_to)
   );

   uart_tx_arbiter #(.NUM_REQ(4), .HEADER_EN(0), .TIMEOUT(8)) dut_n (
      .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
      .i_req_last(req_last), .o_req_ready(n_req_ready), .o_tx_valid(n_tx_valid),
      .o_tx_data(n_tx_data), .i_tx_ready(tx_ready), .o_grant(n_grant),
      .o_busy(n_busy), .o_timeout_evt(n_to_evt)
   );

   assign w_req_ready = use_n ? n_req_ready : h_req_ready;
   assign w_grant     = use_n ? n_grant     : h_grant;
   assign w_tx_data   = use_n ? n_tx_data   : h_tx_data;
   assign w_tx_valid  = use_n ? n_tx_valid  : h_tx_valid;
   assign w_busy      = use_n ? n_busy      : h_busy;
   assign w_timeout   = use_n ? n_to_evt    : h_to;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Requester model: each requester streams its own byte list, popping on handshake
   initial begin
      logic [3:0] acc;
      for (int i = 0; i < 4; i++) rhead[i] = 0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) acc[i] = !rst && w_req_ready[i] && req_valid[i];
         @(posedge clk);
         #2;
         for (int i = 0; i < 4; i++) begin
            if (acc[i]) rhead[i]++;
            req_valid[i] = (rhead[i] != rtail[i]);
            if (req_valid[i]) {req_last[i], req_data[i*8 +: 8]} = rmem[i][rhead[i]];
            else              {req_last[i], req_data[i*8 +: 8]} = 9'd0;
         end
      end
   end

   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #3;
         case (tx_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'b0;
         endcase
      end
   end

   // Monitor: every byte accepted by uart_tx is popped from the scoreboard
   initial begin
      exp_t e;
      int   ref_c;
      last_xfer = 0;
      n_to      = 0;
      forever begin
         @(negedge clk);
         if (!rst && w_tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_xfer: got byte 0x%0h with no byte expected (cycle %0d)", w_tx_data, cyc);
            end else begin
               e = sb.pop_front();
               chk("tx_data", 32'(w_tx_data), 32'(e.data));
               chk("grant_at_xfer", 32'(w_grant), 32'(e.gnt));
               if (e.gap != 0) begin
                  ref_c = e.from_mark ? mark_cyc : last_xfer;
                  chk("xfer_cycle_gap", cyc - ref_c, 32'(e.gap));
               end
            end
            last_xfer = cyc;
         end
         if (!rst && (|w_req_ready)) begin
            chk("req_ready_needs_tx_ready", 32'(tx_ready), 32'd1);
            chk("req_ready_is_grant", 32'(w_req_ready), 32'(w_grant));
         end
         if (w_timeout) begin
            n_to++;
            if (exp_to_gap != 0) chk("timeout_gap", cyc - last_xfer, exp_to_gap);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic enq(input int r, input logic [7:0] d, input logic last);
      rmem[r][rtail[r]] = {last, d};
      rtail[r]++;
   endtask

   task automatic expect_x(input logic [7:0] d, input logic [3:0] g, input int gap, input logic fm);
      exp_t e;
      e.data      = d;
      e.gnt       = g;
      e.gap       = 16'(gap);
      e.from_mark = fm;
      sb.push_back(e);
   endtask

   function automatic bit pending();
      bit p = (sb.size() != 0);
      for (int i = 0; i < 4; i++) if (rhead[i] != rtail[i]) p = 1'b1;
      return p;
   endfunction

   task automatic drain(input string name);
      int k = 0;
      while (pending() && k < 300) begin
         tick(1);
         k++;
      end
      chk({name, "_drained"}, 32'(k < 300), 32'd1);
      tick(3);
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_tx_valid"},  32'(w_tx_valid),  32'd0);
      chk({name, "_req_ready"}, 32'(w_req_ready), 32'd0);
      chk({name, "_grant"},     32'(w_grant),     32'd0);
      chk({name, "_busy"},      32'(w_busy),      32'd0);
      chk({name, "_timeout"},   32'(w_timeout),   32'd0);
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      rst        = 1'b1;
      use_n      = 1'b0;
      tx_mode    = 0;
      mark_cyc   = 0;
      exp_to_gap = 0;
      for (int i = 0; i < 4; i++) rtail[i] = 0;

      tick(2);
      @(negedge clk);
      chk_idle("reset");
      chk("reset_tx_data", 32'(w_tx_data), 32'd0);
      tick(1);
      rst = 1'b0;

      // Single requester with header: A2, 55, 66 back to back
      mark_cyc = cyc;
      enq(2, 8'h55, 1'b0);
      enq(2, 8'h66, 1'b1);
      expect_x(8'hA2, 4'b0100, 1, 1'b1);
      expect_x(8'h55, 4'b0100, 1, 1'b0);
      expect_x(8'h66, 4'b0100, 1, 1'b0);
      drain("single");
      @(negedge clk);
      chk_idle("single_done");

      // Round-robin without header: grant order 0,1,2,3,0 with one idle cycle between
      tick(1);
      use_n = 1'b1;
      do_reset();
      mark_cyc = cyc;
      enq(0, 8'h10, 1'b1);
      enq(0, 8'h14, 1'b1);
      enq(1, 8'h21, 1'b1);
      enq(2, 8'h32, 1'b1);
      enq(3, 8'h43, 1'b1);
      expect_x(8'h10, 4'b0001, 1, 1'b1);
      expect_x(8'h21, 4'b0010, 2, 1'b0);
      expect_x(8'h32, 4'b0100, 2, 1'b0);
      expect_x(8'h43, 4'b1000, 2, 1'b0);
      expect_x(8'h14, 4'b0001, 2, 1'b0);
      drain("round_robin");
      use_n = 1'b0;

      // Backpressure: header held 12 cycles (never times out), then ready toggles
      do_reset();
      tx_mode = 2;
      enq(0, 8'h81, 1'b0);
      enq(0, 8'h82, 1'b0);
      enq(0, 8'h83, 1'b0);
      enq(0, 8'h84, 1'b1);
      expect_x(8'hA0, 4'b0001, 0, 1'b0);
      expect_x(8'h81, 4'b0001, 0, 1'b0);
      expect_x(8'h82, 4'b0001, 0, 1'b0);
      expect_x(8'h83, 4'b0001, 0, 1'b0);
      expect_x(8'h84, 4'b0001, 0, 1'b0);
      tick(12);
      tx_mode = 1;
      drain("backpressure");
      tx_mode = 0;
      tick(1);
      chk("timeouts_after_backpressure", n_to, 0);

      // Timeout: req 1 stalls after one byte, revoked 9 cycles after that byte
      do_reset();
      exp_to_gap = 9;
      mark_cyc = cyc;
      enq(1, 8'h11, 1'b0);
      enq(3, 8'h33, 1'b1);
      expect_x(8'hA1, 4'b0010, 1, 1'b1);
      expect_x(8'h11, 4'b0010, 1, 1'b0);
      expect_x(8'hA3, 4'b1000, 10, 1'b0);
      expect_x(8'h33, 4'b1000, 1, 1'b0);
      drain("timeout");
      chk("timeouts_after_timeout", n_to, 1);
      exp_to_gap = 0;

      // Lock: req 1 arrives mid-packet and waits for the idle cycle
      do_reset();
      mark_cyc = cyc;
      enq(0, 8'h01, 1'b0);
      enq(0, 8'h02, 1'b0);
      enq(0, 8'h03, 1'b1);
      expect_x(8'hA0, 4'b0001, 1, 1'b1);
      expect_x(8'h01, 4'b0001, 1, 1'b0);
      expect_x(8'h02, 4'b0001, 1, 1'b0);
      expect_x(8'h03, 4'b0001, 1, 1'b0);
      expect_x(8'hA1, 4'b0010, 2, 1'b0);
      expect_x(8'h99, 4'b0010, 1, 1'b0);
      tick(2);
      enq(1, 8'h99, 1'b1);
      drain("lock");

      // Reset in DATA aborts the packet; the remaining bytes get a fresh grant
      do_reset();
      mark_cyc = cyc;
      enq(2, 8'h5A, 1'b0);
      enq(2, 8'h5B, 1'b0);
      enq(2, 8'h5C, 1'b1);
      expect_x(8'hA2, 4'b0100, 1, 1'b1);
      expect_x(8'h5A, 4'b0100, 1, 1'b0);
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      mark_cyc = cyc;
      expect_x(8'hA2, 4'b0100, 1, 1'b1);
      expect_x(8'h5B, 4'b0100, 1, 1'b0);
      expect_x(8'h5C, 4'b0100, 1, 1'b0);
      @(negedge clk);
      chk_idle("after_mid_reset");
      chk("after_mid_reset_tx_data", 32'(w_tx_data), 32'd0);
      drain("mid_reset");
      chk("timeouts_final", n_to, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
